// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module : seg7_pkg
// Segment patterns ({g,f,e,d,c,b,a}, active-high), decoder and sizing helpers.
// Rev    : 1.0
// ============================================================================
package seg7_pkg;

  localparam logic [6:0] c_seg_0     = 7'h3F;
  localparam logic [6:0] c_seg_1     = 7'h06;
  localparam logic [6:0] c_seg_2     = 7'h5B;
  localparam logic [6:0] c_seg_3     = 7'h4F;
  localparam logic [6:0] c_seg_4     = 7'h66;
  localparam logic [6:0] c_seg_5     = 7'h6D;
  localparam logic [6:0] c_seg_6     = 7'h7D;
  localparam logic [6:0] c_seg_7     = 7'h07;
  localparam logic [6:0] c_seg_8     = 7'h7F;
  localparam logic [6:0] c_seg_9     = 7'h6F;
  localparam logic [6:0] c_seg_blank = 7'h00;

  // Codes A..F never reach the decoder in normal operation; show them dark.
  function automatic logic [6:0] seg7_decode(input logic [3:0] nibble);
    case (nibble)
      4'd0:    return c_seg_0;
      4'd1:    return c_seg_1;
      4'd2:    return c_seg_2;
      4'd3:    return c_seg_3;
      4'd4:    return c_seg_4;
      4'd5:    return c_seg_5;
      4'd6:    return c_seg_6;
      4'd7:    return c_seg_7;
      4'd8:    return c_seg_8;
      4'd9:    return c_seg_9;
      default: return c_seg_blank;
    endcase
  endfunction

  // Width of the tick divider for a given division ratio.
  function automatic int div_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

  // Binary to packed BCD, up to eight digits.
  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int          x;
    r = '0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ============================================================================
// Module : bcd_digit
// One decimal digit of the counter with carry/borrow out to the next digit.
// Rev    : 1.0
// ============================================================================
module bcd_digit #(
  parameter logic [3:0] MAX_DIGIT = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] d,
  input  logic       set_zero,
  input  logic       set_max_digit,
  output logic [3:0] q,
  output logic       carry_out,
  output logic       borrow_out
);

  logic [3:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= d;
    end else if (set_zero) begin
      r_q <= '0;
    end else if (set_max_digit) begin
      r_q <= MAX_DIGIT;
    end else if (step) begin
      if (up) begin
        r_q <= (r_q == 4'd9) ? 4'd0 : r_q + 4'd1;
      end else begin
        r_q <= (r_q == 4'd0) ? 4'd9 : r_q - 4'd1;
      end
    end
  end

  assign q          = r_q;
  assign carry_out  = step & up & (r_q == 4'd9);
  assign borrow_out = step & ~up & (r_q == 4'd0);

endmodule
`default_nettype wire

// File: rtl/seg7_bcd_counter.sv
`default_nettype none
// ============================================================================
// Module : seg7_bcd_counter
// N-digit BCD up/down counter with tick divider, load, modulus and 7-seg out.
// Rev    : 1.0
// ============================================================================
module seg7_bcd_counter #(
  parameter int DIGITS         = 2,
  parameter int CLK_HZ         = 50_000_000,
  parameter int TICK_HZ        = 1,
  parameter int MAX_VAL        = 99,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int BLANK_LZ       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  up,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  tick,
  output logic                  wrap,
  output logic                  load_err
);

  import seg7_pkg::*;

  localparam int                   c_div          = CLK_HZ / TICK_HZ;
  localparam int                   c_div_w        = div_width(c_div);
  localparam logic [c_div_w-1:0]   c_div_last     = c_div_w'(c_div - 1);
  localparam logic [31:0]          c_max_bcd_full = to_bcd(MAX_VAL);
  localparam logic [4*DIGITS-1:0]  c_max_bcd      = c_max_bcd_full[4*DIGITS-1:0];

  logic [c_div_w-1:0]   r_div;
  logic                 r_tick;
  logic                 r_wrap;
  logic                 r_load_err;
  logic [7*DIGITS-1:0]  r_seg;

  logic [4*DIGITS-1:0]  w_bcd;
  logic [DIGITS-1:0]    w_carry;
  logic [DIGITS-1:0]    w_borrow;
  logic                 w_load_ok;
  logic                 w_load_acc;
  logic                 w_count;
  logic                 w_at_max;
  logic                 w_at_zero;
  logic                 w_wrap_up;
  logic                 w_wrap_dn;
  logic                 w_step0;
  logic                 w_unused_msd;

  // With every nibble valid, packed-BCD order equals numeric order.
  always_comb begin
    w_load_ok = (load_val <= c_max_bcd);
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) begin
        w_load_ok = 1'b0;
      end
    end
  end

  assign w_load_acc = load & w_load_ok;
  assign w_count    = r_tick & en & ~load;
  assign w_at_max   = (w_bcd == c_max_bcd);
  assign w_at_zero  = (w_bcd == '0);
  assign w_wrap_up  = w_count & up & w_at_max;
  assign w_wrap_dn  = w_count & ~up & w_at_zero;
  assign w_step0    = w_count & ~(up ? w_at_max : w_at_zero);

  genvar gi;
  for (gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic w_step_in;
    if (gi == 0) begin : g_lsd
      assign w_step_in = w_step0;
    end else begin : g_upper
      assign w_step_in = w_carry[gi-1] | w_borrow[gi-1];
    end

    bcd_digit #(
      .MAX_DIGIT (c_max_bcd[4*gi +: 4])
    ) u_digit (
      .clk           (clk),
      .rst           (rst),
      .step          (w_step_in),
      .up            (up),
      .load          (w_load_acc),
      .d             (load_val[4*gi +: 4]),
      .set_zero      (w_wrap_up),
      .set_max_digit (w_wrap_dn),
      .q             (w_bcd[4*gi +: 4]),
      .carry_out     (w_carry[gi]),
      .borrow_out    (w_borrow[gi])
    );
  end

  // The top digit's carry/borrow has nowhere to go; wrap is decided above.
  assign w_unused_msd = w_carry[DIGITS-1] | w_borrow[DIGITS-1];

  function automatic logic [7*DIGITS-1:0] seg_pattern(input logic [4*DIGITS-1:0] v);
    logic [7*DIGITS-1:0] p;
    logic                zero_above;
    logic [6:0]          s;
    p          = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (v[4*i +: 4] == 4'd0);
      s = ((BLANK_LZ != 0) && (i > 0) && zero_above) ? c_seg_blank
                                                     : seg7_decode(v[4*i +: 4]);
      p[7*i +: 7] = (SEG_ACTIVE_LOW != 0) ? ~s : s;
    end
    return p;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div      <= '0;
      r_tick     <= 1'b0;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
      r_seg      <= seg_pattern('0);
    end else begin
      if (load || (r_div == c_div_last)) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + 1'b1;
      end
      // A load restarts the tick period, so a pending tick is dropped too.
      r_tick     <= ~load & (r_div == c_div_last);
      r_wrap     <= w_wrap_up | w_wrap_dn;
      r_load_err <= load & ~w_load_ok;
      r_seg      <= seg_pattern(w_bcd);
    end
  end

  assign bcd      = w_bcd;
  assign seg      = r_seg;
  assign tick     = r_tick;
  assign wrap     = r_wrap;
  assign load_err = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_seg7_bcd_counter.sv
`default_nettype none
// ============================================================================
// Module : tb_seg7_bcd_counter
// Scoreboarded bench: three counter configurations share one stimulus stream.
// Rev    : 1.0
// ============================================================================
module tb_seg7_bcd_counter;

  typedef struct {
    logic [7:0]  bcd_a;
    logic [7:0]  bcd_b;
    logic        tick;
    logic        wrap_a;
    logic        wrap_b;
    logic        err_a;
    logic        err_b;
    logic [13:0] seg_a;
    logic [13:0] seg_b;
    logic [13:0] seg_c;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, up, en, load;
  logic [7:0]  load_val;
  logic [7:0]  bcd_a, bcd_b, bcd_c;
  logic [13:0] seg_a, seg_b, seg_c;
  logic        tick_a, tick_b, tick_c;
  logic        wrap_a, wrap_b, wrap_c;
  logic        err_a, err_b, err_c;

  int n_checks = 0;
  int n_errors = 0;

  exp_t sb_q[$];
  int   m_v[2];
  int   m_div;
  bit   m_tick;

  // a: MAX 99, plain active-high; b: MAX 59; c: MAX 99, blanking, active-low
  seg7_bcd_counter #(.DIGITS(2), .CLK_HZ(4), .TICK_HZ(1), .MAX_VAL(99),
                     .SEG_ACTIVE_LOW(0), .BLANK_LZ(0)) dut_a (
    .clk(clk), .rst(rst), .up(up), .en(en), .load(load), .load_val(load_val),
    .bcd(bcd_a), .seg(seg_a), .tick(tick_a), .wrap(wrap_a), .load_err(err_a));

  seg7_bcd_counter #(.DIGITS(2), .CLK_HZ(4), .TICK_HZ(1), .MAX_VAL(59),
                     .SEG_ACTIVE_LOW(0), .BLANK_LZ(0)) dut_b (
    .clk(clk), .rst(rst), .up(up), .en(en), .load(load), .load_val(load_val),
    .bcd(bcd_b), .seg(seg_b), .tick(tick_b), .wrap(wrap_b), .load_err(err_b));

  seg7_bcd_counter #(.DIGITS(2), .CLK_HZ(4), .TICK_HZ(1), .MAX_VAL(99),
                     .SEG_ACTIVE_LOW(1), .BLANK_LZ(1)) dut_c (
    .clk(clk), .rst(rst), .up(up), .en(en), .load(load), .load_val(load_val),
    .bcd(bcd_c), .seg(seg_c), .tick(tick_c), .wrap(wrap_c), .load_err(err_c));

  function automatic logic [6:0] seg_tab(input logic [3:0] n);
    case (n)
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
      4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
      4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
      4'd9: return 7'h6F;  default: return 7'h00;
    endcase
  endfunction

  function automatic logic [13:0] pat(input logic [7:0] b, input bit blank_lz, input bit act_low);
    logic [13:0] p;
    p[6:0]  = seg_tab(b[3:0]);
    p[13:7] = (blank_lz && b[7:4] == 4'd0) ? 7'h00 : seg_tab(b[7:4]);
    return act_low ? ~p : p;
  endfunction

  function automatic logic [7:0] int2bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int bcd2int(input logic [7:0] b);
    return 10 * int'(b[7:4]) + int'(b[3:0]);
  endfunction

  // Predict the outputs after the coming edge, queue them, then take the edge.
  task automatic drive_cycle();
    exp_t       e;
    logic [7:0] prev_a, prev_b;
    bit         wr[2], er[2];
    int         maxv[2];
    maxv[0] = 99;
    maxv[1] = 59;
    prev_a  = rst ? 8'h00 : int2bcd(m_v[0]);
    prev_b  = rst ? 8'h00 : int2bcd(m_v[1]);
    for (int k = 0; k < 2; k++) begin
      wr[k] = 1'b0;
      er[k] = 1'b0;
    end
    if (rst) begin
      m_div  = 0;
      m_tick = 1'b0;
      m_v[0] = 0;
      m_v[1] = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (load) begin
          if (load_val[7:4] <= 4'd9 && load_val[3:0] <= 4'd9 && bcd2int(load_val) <= maxv[k])
            m_v[k] = bcd2int(load_val);
          else
            er[k] = 1'b1;
        end else if (m_tick && en) begin
          if (up) begin
            if (m_v[k] == maxv[k]) begin m_v[k] = 0; wr[k] = 1'b1; end
            else m_v[k] = m_v[k] + 1;
          end else begin
            if (m_v[k] == 0) begin m_v[k] = maxv[k]; wr[k] = 1'b1; end
            else m_v[k] = m_v[k] - 1;
          end
        end
      end
      m_tick = !load && (m_div == 3);
      m_div  = (load || m_div == 3) ? 0 : m_div + 1;
    end
    e.bcd_a  = int2bcd(m_v[0]);
    e.bcd_b  = int2bcd(m_v[1]);
    e.tick   = m_tick;
    e.wrap_a = wr[0];
    e.wrap_b = wr[1];
    e.err_a  = er[0];
    e.err_b  = er[1];
    e.seg_a  = pat(prev_a, 1'b0, 1'b0);
    e.seg_b  = pat(prev_b, 1'b0, 1'b0);
    e.seg_c  = pat(prev_a, 1'b1, 1'b1);
    sb_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Scoreboard consumer: every edge that had a prediction is compared here.
  initial begin : sb_monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_checks += 6;
        if ({bcd_a, tick_a, wrap_a, err_a} !== {e.bcd_a, e.tick, e.wrap_a, e.err_a}) begin
          n_errors++;
          $display("FAIL sb_a t=%0t got bcd=%h tick=%b wrap=%b err=%b exp bcd=%h tick=%b wrap=%b err=%b",
                   $time, bcd_a, tick_a, wrap_a, err_a, e.bcd_a, e.tick, e.wrap_a, e.err_a);
        end
        if ({bcd_b, tick_b, wrap_b, err_b} !== {e.bcd_b, e.tick, e.wrap_b, e.err_b}) begin
          n_errors++;
          $display("FAIL sb_b t=%0t got bcd=%h tick=%b wrap=%b err=%b exp bcd=%h tick=%b wrap=%b err=%b",
                   $time, bcd_b, tick_b, wrap_b, err_b, e.bcd_b, e.tick, e.wrap_b, e.err_b);
        end
        if ({bcd_c, tick_c, wrap_c, err_c} !== {e.bcd_a, e.tick, e.wrap_a, e.err_a}) begin
          n_errors++;
          $display("FAIL sb_c t=%0t got bcd=%h tick=%b wrap=%b err=%b exp bcd=%h tick=%b wrap=%b err=%b",
                   $time, bcd_c, tick_c, wrap_c, err_c, e.bcd_a, e.tick, e.wrap_a, e.err_a);
        end
        if (seg_a !== e.seg_a) begin
          n_errors++;
          $display("FAIL sb_seg_a t=%0t got=%h exp=%h", $time, seg_a, e.seg_a);
        end
        if (seg_b !== e.seg_b) begin
          n_errors++;
          $display("FAIL sb_seg_b t=%0t got=%h exp=%h", $time, seg_b, e.seg_b);
        end
        if (seg_c !== e.seg_c) begin
          n_errors++;
          $display("FAIL sb_seg_c t=%0t got=%h exp=%h", $time, seg_c, e.seg_c);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; up = 1'b1; en = 1'b0; load = 1'b0; load_val = 8'h00;
    m_v[0] = 0; m_v[1] = 0; m_div = 0; m_tick = 1'b0;
    drive_cycle();
    drive_cycle();
    n_checks += 2;
    if ({bcd_a, tick_a, wrap_a, err_a, seg_a} !== {8'h00, 1'b0, 1'b0, 1'b0, 14'h1FBF}) begin
      n_errors++;
      $display("FAIL reset_a got bcd=%h tick=%b wrap=%b err=%b seg=%h exp 00/0/0/0/1fbf",
               bcd_a, tick_a, wrap_a, err_a, seg_a);
    end
    if (seg_c !== {7'h7F, 7'h40}) begin
      n_errors++;
      $display("FAIL reset_seg_blank got=%h exp=%h", seg_c, {7'h7F, 7'h40});
    end
  endtask

  task automatic test_count_up();
    rst = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      drive_cycle();
      n_checks++;
      if (tick_a !== (i % 4 == 0)) begin
        n_errors++;
        $display("FAIL count_up_tick cycle=%0d got=%b exp=%b", i, tick_a, (i % 4 == 0));
      end
      if (i == 5 || i == 6 || i == 10) begin
        n_checks++;
        if (seg_a[6:0] !== ((i == 5) ? 7'h3F : (i == 6) ? 7'h06 : 7'h5B)) begin
          n_errors++;
          $display("FAIL count_up_seg cycle=%0d got=%h", i, seg_a[6:0]);
        end
      end
    end
    n_checks++;
    if (bcd_a !== 8'h03) begin
      n_errors++;
      $display("FAIL count_up_bcd got=%h exp=03", bcd_a);
    end
  endtask

  task automatic test_wrap_up();
    load = 1'b1; load_val = 8'h98; drive_cycle(); load = 1'b0;
    n_checks++;
    if (bcd_a !== 8'h98) begin n_errors++; $display("FAIL load_98 got=%h exp=98", bcd_a); end
    for (int j = 1; j <= 10; j++) begin
      drive_cycle();
      if (j == 5) begin
        n_checks++;
        if (bcd_a !== 8'h99) begin n_errors++; $display("FAIL up_to_99 got=%h exp=99", bcd_a); end
      end
      if (j == 9 || j == 10) begin
        n_checks++;
        if ({bcd_a, wrap_a} !== {8'h00, (j == 9)}) begin
          n_errors++;
          $display("FAIL up_wrap j=%0d got bcd=%h wrap=%b exp bcd=00 wrap=%b", j, bcd_a, wrap_a, (j == 9));
        end
      end
    end
    load = 1'b1; load_val = 8'h09; drive_cycle(); load = 1'b0;
    for (int j = 1; j <= 5; j++) drive_cycle();
    n_checks++;
    if (bcd_a !== 8'h10) begin n_errors++; $display("FAIL carry_09_10 got=%h exp=10", bcd_a); end
  endtask

  task automatic test_wrap_down();
    up = 1'b0;
    load = 1'b1; load_val = 8'h00; drive_cycle(); load = 1'b0;
    for (int j = 1; j <= 9; j++) begin
      drive_cycle();
      if (j == 5 || j == 9) begin
        n_checks++;
        if ({bcd_a, wrap_a} !== ((j == 5) ? {8'h99, 1'b1} : {8'h98, 1'b0})) begin
          n_errors++;
          $display("FAIL down_wrap j=%0d got bcd=%h wrap=%b", j, bcd_a, wrap_a);
        end
      end
    end
    load = 1'b1; load_val = 8'h10; drive_cycle(); load = 1'b0;
    for (int j = 1; j <= 5; j++) drive_cycle();
    n_checks++;
    if (bcd_a !== 8'h09) begin n_errors++; $display("FAIL borrow_10_09 got=%h exp=09", bcd_a); end
  endtask

  task automatic test_invalid_load();
    up = 1'b1;
    load = 1'b1; load_val = 8'h42; drive_cycle();
    load_val = 8'h75; drive_cycle();
    n_checks++;
    if ({bcd_b, err_b, bcd_a, err_a} !== {8'h42, 1'b1, 8'h75, 1'b0}) begin
      n_errors++;
      $display("FAIL load_75 got b=%h/%b a=%h/%b exp b=42/1 a=75/0", bcd_b, err_b, bcd_a, err_a);
    end
    load_val = 8'h4A; drive_cycle();
    n_checks++;
    if ({bcd_b, err_b, bcd_a, err_a} !== {8'h42, 1'b1, 8'h75, 1'b1}) begin
      n_errors++;
      $display("FAIL load_4A got b=%h/%b a=%h/%b exp b=42/1 a=75/1", bcd_b, err_b, bcd_a, err_a);
    end
    load_val = 8'h59; drive_cycle(); load = 1'b0;
    for (int j = 1; j <= 5; j++) drive_cycle();
    n_checks++;
    if ({bcd_b, wrap_b, bcd_a, wrap_a} !== {8'h00, 1'b1, 8'h60, 1'b0}) begin
      n_errors++;
      $display("FAIL wrap_59 got b=%h/%b a=%h/%b exp b=00/1 a=60/0", bcd_b, wrap_b, bcd_a, wrap_a);
    end
  endtask

  task automatic test_blank();
    load = 1'b1; load_val = 8'h05; drive_cycle(); load = 1'b0;
    drive_cycle();
    n_checks++;
    if (seg_c !== {7'h7F, 7'h12}) begin
      n_errors++;
      $display("FAIL blank_05 got=%h exp=%h", seg_c, {7'h7F, 7'h12});
    end
    load = 1'b1; load_val = 8'h00; drive_cycle(); load = 1'b0;
    drive_cycle();
    n_checks++;
    if (seg_c !== {7'h7F, 7'h40}) begin
      n_errors++;
      $display("FAIL blank_00 got=%h exp=%h", seg_c, {7'h7F, 7'h40});
    end
  endtask

  task automatic test_coincident();
    bit found;
    int ticks;
    found = 1'b0;
    en = 1'b1; up = 1'b1;
    for (int n = 0; n < 8 && !found; n++) begin
      drive_cycle();
      if (tick_a === 1'b1) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL find_tick got=no tick within 8 cycles exp=tick");
    end
    load = 1'b1; load_val = 8'h30; drive_cycle(); load = 1'b0;
    n_checks++;
    if (bcd_a !== 8'h30) begin n_errors++; $display("FAIL load_vs_tick got=%h exp=30", bcd_a); end
    for (int j = 1; j <= 4; j++) begin
      drive_cycle();
      n_checks++;
      if (tick_a !== (j == 4)) begin
        n_errors++;
        $display("FAIL tick_after_load j=%0d got=%b exp=%b", j, tick_a, (j == 4));
      end
    end
    rst = 1'b1; load = 1'b1; load_val = 8'h4A; drive_cycle(); rst = 1'b0; load = 1'b0;
    n_checks++;
    if ({bcd_a, err_a, bcd_b, err_b} !== {8'h00, 1'b0, 8'h00, 1'b0}) begin
      n_errors++;
      $display("FAIL rst_with_load got a=%h/%b b=%h/%b exp 00/0", bcd_a, err_a, bcd_b, err_b);
    end
    en = 1'b0;
    load = 1'b1; load_val = 8'h99; drive_cycle(); load = 1'b0;
    ticks = 0;
    for (int j = 1; j <= 12; j++) begin
      drive_cycle();
      if (tick_a === 1'b1) ticks++;
      n_checks++;
      if ({bcd_a, wrap_a} !== {8'h99, 1'b0}) begin
        n_errors++;
        $display("FAIL en_off_hold j=%0d got bcd=%h wrap=%b exp 99/0", j, bcd_a, wrap_a);
      end
    end
    n_checks++;
    if (ticks != 3) begin n_errors++; $display("FAIL en_off_ticks got=%0d exp=3", ticks); end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    test_reset();
    test_count_up();
    test_wrap_up();
    test_wrap_down();
    test_invalid_load();
    test_blank();
    test_coincident();
    #5;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL sb_drain got=%0d pending exp=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
